// File: rtl/set_clear_flag.sv
// rtl/set_clear_flag.sv - bank of sticky set/clear flags with edge pulses
// Optional sticky set/clear collision tracking via REG_SET_CLEAR_COLLISION_EN.
module set_clear_flag #(
  parameter int               WIDTH     = 1,
  parameter bit               SET_WINS  = 1'b0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clear,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rose,
  output logic [WIDTH-1:0] fell,
  output logic             any,
  output logic [WIDTH-1:0] collision
);

  logic [WIDTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] rose_q, rose_d;
  logic [WIDTH-1:0] fell_q, fell_d;

  always_comb begin
    flag_d = flag_q;
    if (SET_WINS) begin
      flag_d = (flag_q & ~clear) | set;
    end else begin
      flag_d = (flag_q | set) & ~clear;
    end
    rose_d = ~flag_q & flag_d;
    fell_d = flag_q & ~flag_d;
  end

  // Reset suppresses pulses, so a reset-induced change of q is silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q <= RESET_VAL;
      rose_q <= '0;
      fell_q <= '0;
    end else begin
      flag_q <= flag_d;
      rose_q <= rose_d;
      fell_q <= fell_d;
    end
  end

`ifdef REG_SET_CLEAR_COLLISION_EN
  logic [WIDTH-1:0] coll_q, coll_d;

  always_comb begin
    coll_d = coll_q | (set & clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      coll_q <= '0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign collision = coll_q;
`else
  assign collision = '0;
`endif

  assign q    = flag_q;
  assign rose = rose_q;
  assign fell = fell_q;
  assign any  = |flag_q;

endmodule

// File: tb/tb_set_clear_flag.sv
// tb/tb_set_clear_flag.sv - self-checking bench for set_clear_flag
// Honours REG_SET_CLEAR_COLLISION_EN to choose collision expectations.
module tb_set_clear_flag;

`ifdef REG_SET_CLEAR_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif
  localparam logic [7:0] RV8 = 8'hA5;

  logic clk;
  logic rst;

  logic       s1, c1, q1, r1, f1, a1, k1;
  logic       ss, cs, qs, rs, fs, as_, ks;
  logic [3:0] s4, c4, q4, r4, f4, k4;
  logic       a4;
  logic [7:0] s8, c8, q8, r8, f8, k8;
  logic       a8;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_q, m_rose, m_fell, m_coll;

  set_clear_flag #(.WIDTH(1), .SET_WINS(1'b0), .RESET_VAL(1'b0)) u_w1 (
    .clk(clk), .reset(rst), .set(s1), .clear(c1), .q(q1), .rose(r1),
    .fell(f1), .any(a1), .collision(k1));

  set_clear_flag #(.WIDTH(1), .SET_WINS(1'b1), .RESET_VAL(1'b0)) u_sw (
    .clk(clk), .reset(rst), .set(ss), .clear(cs), .q(qs), .rose(rs),
    .fell(fs), .any(as_), .collision(ks));

  set_clear_flag #(.WIDTH(4), .SET_WINS(1'b0), .RESET_VAL(4'h0)) u_w4 (
    .clk(clk), .reset(rst), .set(s4), .clear(c4), .q(q4), .rose(r4),
    .fell(f4), .any(a4), .collision(k4));

  set_clear_flag #(.WIDTH(8), .SET_WINS(1'b1), .RESET_VAL(RV8)) u_w8 (
    .clk(clk), .reset(rst), .set(s8), .clear(c8), .q(q8), .rose(r8),
    .fell(f8), .any(a8), .collision(k8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference for the 8-bit set-wins instance, stepped on every clock edge.
  task automatic tick();
    logic [7:0] nq, nr, nf, nc;
    if (rst) begin
      nq = RV8; nr = '0; nf = '0; nc = '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic b;
        if (s8[i] && c8[i]) b = 1'b1;
        else if (s8[i])     b = 1'b1;
        else if (c8[i])     b = 1'b0;
        else                b = m_q[i];
        nq[i] = b;
        nr[i] = !m_q[i] && b;
        nf[i] = m_q[i] && !b;
        nc[i] = COLL_EN ? (m_coll[i] | (s8[i] & c8[i])) : 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_q = nq; m_rose = nr; m_fell = nf; m_coll = nc;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] set;
    logic [3:0] clr;
    logic [3:0] q;
    logic [3:0] rose;
    logic [3:0] fell;
    logic       any;
    logic [3:0] coll;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst = 1'b1;
    s1 = 0; c1 = 0; ss = 0; cs = 0; s4 = '0; c4 = '0; s8 = '0; c8 = '0;
    m_q = RV8; m_rose = '0; m_fell = '0; m_coll = '0;

    //          rst   set    clr    q      rose   fell   any   coll
    vecs[0]  = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[1]  = '{1'b0, 4'h5, 4'h0, 4'h5, 4'h5, 4'h0, 1'b1, 4'h0};
    vecs[2]  = '{1'b0, 4'h0, 4'h1, 4'h4, 4'h0, 4'h1, 1'b1, 4'h0};
    vecs[3]  = '{1'b0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1, 4'h0};
    vecs[4]  = '{1'b0, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0, 1'b1, 4'h0};
    vecs[5]  = '{1'b0, 4'h0, 4'h2, 4'h4, 4'h0, 4'h0, 1'b1, 4'h0};
    vecs[6]  = '{1'b0, 4'hA, 4'h8, 4'h6, 4'h2, 4'h0, 1'b1, 4'h8};
    vecs[7]  = '{1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h6, 1'b0, 4'hF};
    vecs[8]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 4'h1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b1, 4'h0};
    vecs[10] = '{1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 4'h0};

    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; s4 = vecs[i].set; c4 = vecs[i].clr;
      tick();
      chk($sformatf("w4_q[%0d]", i), q4, vecs[i].q);
      chk($sformatf("w4_rose[%0d]", i), r4, vecs[i].rose);
      chk($sformatf("w4_fell[%0d]", i), f4, vecs[i].fell);
      chk($sformatf("w4_any[%0d]", i), a4, vecs[i].any);
      chk($sformatf("w4_coll[%0d]", i), k4, COLL_EN ? vecs[i].coll : 4'h0);
    end
    s4 = '0; c4 = '0;

    // Reset overrides set; rose appears one edge after release.
    rst = 1'b1; s1 = 1'b1;
    tick();
    chk("w1_rst_q", q1, 0); chk("w1_rst_rose", r1, 0);
    tick();
    chk("w1_rst2_q", q1, 0); chk("w1_rst2_any", a1, 0); chk("w1_rst_coll", k1, 0);
    rst = 1'b0;
    tick();
    chk("w1_rel_q", q1, 1); chk("w1_rel_rose", r1, 1);
    tick();
    chk("w1_hold_q", q1, 1); chk("w1_hold_rose", r1, 0); chk("w1_hold_any", a1, 1);

    // Clear pulse, then redundant clear.
    s1 = 1'b0; c1 = 1'b1;
    tick();
    chk("w1_clr_q", q1, 0); chk("w1_clr_fell", f1, 1); chk("w1_clr_any", a1, 0);
    c1 = 1'b0;
    tick();
    chk("w1_clr_fell_drop", f1, 0);
    c1 = 1'b1;
    tick();
    chk("w1_reclr_q", q1, 0); chk("w1_reclr_fell", f1, 0);

    // Collision with clear-wins from q=1.
    c1 = 1'b0; s1 = 1'b1;
    tick();
    chk("w1_pre_coll_q", q1, 1);
    s1 = 1'b1; c1 = 1'b1;
    tick();
    chk("w1_coll_q", q1, 0); chk("w1_coll_fell", f1, 1); chk("w1_coll_flag", k1, COLL_EN);
    s1 = 1'b0; c1 = 1'b0;
    tick();
    chk("w1_coll_sticky", k1, COLL_EN); chk("w1_coll_fell_drop", f1, 0);

    // Set-wins instance, idle since reset, so q=0 before the collision.
    chk("sw_pre_q", qs, 0);
    ss = 1'b1; cs = 1'b1;
    tick();
    chk("sw_coll_q", qs, 1); chk("sw_coll_rose", rs, 1); chk("sw_coll_flag", ks, COLL_EN);
    ss = 1'b0; cs = 1'b0;
    tick();
    chk("sw_hold_q", qs, 1); chk("sw_rose_drop", rs, 0); chk("sw_sticky", ks, COLL_EN);

    // Frame-drop: set at cycle 3, tlast clear at cycle 9; second pass resets at 6.
    for (int run = 0; run < 2; run++) begin
      rst = 1'b1; s1 = 0; c1 = 0;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
        s1  = (c == 3);
        c1  = (c == 9);
        rst = (run == 1) && (c == 6);
        tick();
        chk($sformatf("fd%0d_q[%0d]", run, c), q1,
            (run == 0) ? (c >= 3 && c < 9) : (c >= 3 && c < 6));
        chk($sformatf("fd%0d_rose[%0d]", run, c), r1, c == 3);
        chk($sformatf("fd%0d_fell[%0d]", run, c), f1, (run == 0) && (c == 9));
      end
    end
    rst = 1'b0; s1 = 0; c1 = 0;

    // Randomized stimulus on the 8-bit set-wins instance against the model.
    rst = 1'b1;
    tick();
    chk("w8_rst_q", q8, RV8); chk("w8_rst_any", a8, 1);
    rst = 1'b0;
    for (int n = 0; n < 400; n++) begin
      s8  = 8'($urandom) & 8'($urandom);
      c8  = 8'($urandom) & 8'($urandom);
      rst = ($urandom_range(0, 39) == 0);
      tick();
      chk($sformatf("w8_q[%0d]", n), q8, m_q);
      chk($sformatf("w8_rose[%0d]", n), r8, m_rose);
      chk($sformatf("w8_fell[%0d]", n), f8, m_fell);
      chk($sformatf("w8_any[%0d]", n), a8, |m_q);
      chk($sformatf("w8_coll[%0d]", n), k8, m_coll);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/set_clear_flag.md
Name: set_clear_flag

Overview:
- Bank of WIDTH independent set/clear flag registers with configurable set/clear priority and edge-pulse outputs.
- Used as a sticky status tracker, e.g. "current frame dropped": set on a drop event, cleared at end of frame (tlast).
- Assertion and monitor logic in the packet-filter datapath read the flag level one cycle after the events that change it.

Parameters:
- WIDTH, 1, number of independent flag bits (>=1).
- SET_WINS, 0, priority when set and clear are both asserted on the same bit: 0 = clear wins, 1 = set wins.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- set  input  WIDTH  per-bit set request, level-sampled each cycle.
- clear  input  WIDTH  per-bit clear request, level-sampled each cycle.
- q  output  WIDTH  registered flag value.
- rose  output  WIDTH  registered one-cycle pulse when q bit went 0->1 on this edge.
- fell  output  WIDTH  registered one-cycle pulse when q bit went 1->0 on this edge.
- any  output  1  combinational OR-reduction of q.
- collision  output  WIDTH  sticky per-bit set/clear collision flag; see Optional Feature.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk.
- Reset:
  - q = RESET_VAL; rose = 0; fell = 0; collision = 0.
  - any follows q, so any = |RESET_VAL.
  - Reset overrides set and clear in the same cycle.
- Per bit i, next-state rule evaluated at each rising edge:
  - set only: q <= 1.
  - clear only: q <= 0.
  - neither: q holds.
  - both: q <= SET_WINS ? 1 : 0.
- Latency: one cycle. A request at edge N is visible on q after edge N.
  - No combinational path from set/clear to q, rose, fell or collision.
- Edge pulses:
  - rose[i] <= ~q[i] & q_next[i]; fell[i] <= q[i] & ~q_next[i].
  - Each pulse is high for exactly one cycle, coincident with the new q value.
  - Set on an already-set bit, or clear on an already-clear bit: no pulse, q unchanged.
- Bits are fully independent; no cross-bit interaction.
- Reset mid-operation: all pulses drop to 0 on the reset edge.
  - No pulse is generated for the reset-induced change of q.
- First cycle after reset deassertion behaves normally. A set in that cycle produces rose on the following edge if RESET_VAL bit is 0.
- X/unknown on set or clear is not sanitized; inputs are required to be driven after reset.

Optional Feature:
- Macro REG_SET_CLEAR_COLLISION_EN.
- Defined:
  - collision[i] <= collision[i] | (set[i] & clear[i]) every cycle.
  - Sticky until reset; registered (one-cycle latency).
  - Does not affect q, which still follows SET_WINS.
- Not defined: collision is tied to all zeros; no collision state registers exist.

Test Plan:
- Reset with RESET_VAL=0, WIDTH=1, set=1 during reset -> q=0, rose=0 while reset=1. After release with set still 1: q=1 and rose=1 one cycle later, rose=0 the next cycle.
- q=1, pulse clear=1 for one cycle -> q=0 next cycle, fell=1 for exactly one cycle, any=0. Then clear=1 again for one cycle -> q stays 0, fell=0.
- SET_WINS=0: set=1 and clear=1 same cycle from q=1 -> q=0, fell=1. SET_WINS=1: same stimulus from q=0 -> q=1, rose=1.
- WIDTH=4: set=4'b0101, then clear=4'b0001 -> q=4'b0101 then 4'b0100; any=1 throughout; rose=4'b0101 then fell=4'b0001.
- Frame-drop use, WIDTH=1: set (drop) at cycle 3, clear (tlast) at cycle 9 -> q=1 for cycles 4..9, q=0 from cycle 10. Reset asserted at cycle 6 forces q=0 from cycle 7 with no fell pulse.
- With REG_SET_CLEAR_COLLISION_EN: set=clear=1 on bit 0 for one cycle -> collision[0]=1 next cycle and held until reset. Without the macro -> collision stays 0.
